// File: rtl/mmips_defs_pkg.sv
// Shared encodings for the mMIPS multicycle controller: opcodes, FSM states,
// datapath mux selects and trap causes.
package mmips_defs;

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_ADDIWB = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mmips_mem_timeout.sv
// Watchdog for an outstanding memory request; expire is combinational so the
// FSM can leave on the TIMEOUT_CYC-th unanswered request cycle.
module mmips_mem_timeout #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic req,
  input  logic ready,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  assign expire = req && !ready && (cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || ready) begin
      cnt <= '0;
    end else if (req) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mmips_ctrl_fsm.sv
// Multicycle mMIPS control FSM: sequences fetch/decode/execute/mem/writeback,
// owns the memory req/ready handshake, traps on illegal opcode or timeout.
module mmips_ctrl_fsm
  import mmips_defs::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_c,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  state_t     state, next_state;
  logic [5:0] op_q;
  logic [1:0] next_cause;
  logic       retire;
  logic       expire;
  logic       tmo_clear;

  // funct belongs to the ALU controller and zero is gated by the datapath via pc_write_c.
  logic unused_inputs;
  assign unused_inputs = ^{funct, zero};

  assign tmo_clear = (next_state != state) && is_mem_state(next_state);

  mmips_mem_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmo_clear),
    .req    (mem_req),
    .ready  (mem_ready),
    .expire (expire)
  );

  always_comb begin
    next_state = state;
    next_cause = CAUSE_NONE;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_write_c = 1'b0;
    pc_src     = PC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    trap       = 1'b0;
    case (state)
      S_RST: next_state = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end else if (expire) begin
          next_state = S_TRAP;
          next_cause = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        case (opcode)
          OP_RTYPE:              next_state = S_EXEC;
          OP_LW, OP_SW, OP_ADDI: next_state = S_MEMADR;
          OP_BEQ:                next_state = S_BRANCH;
          OP_J:                  next_state = S_JUMP;
          default: begin
            next_state = S_TRAP;
            next_cause = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        case (op_q)
          OP_LW:   next_state = S_MEMRD;
          OP_SW:   next_state = S_MEMWR;
          OP_ADDI: next_state = S_ADDIWB;
          default: begin
            next_state = S_TRAP;
            next_cause = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          next_state = S_MEMWB;
        end else if (expire) begin
          next_state = S_TRAP;
          next_cause = CAUSE_TIMEOUT;
        end
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) begin
          next_state = S_FETCH;
          retire     = 1'b1;
        end else if (expire) begin
          next_state = S_TRAP;
          next_cause = CAUSE_TIMEOUT;
        end
      end
      S_EXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_RT;
        alu_op     = ALU_FUNCT;
        next_state = S_RWB;
      end
      S_RWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_RT;
        alu_op     = ALU_SUB;
        pc_write_c = 1'b1;
        pc_src     = PC_ALUOUT;
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = PC_JUMP;
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_TRAP: trap = 1'b1;
      default: next_state = S_RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RST;
      op_q       <= '0;
      retired    <= '0;
      trap_cause <= CAUSE_NONE;
    end else begin
      state <= next_state;
      if (state == S_DECODE) op_q <= opcode;
      if (retire) retired <= retired + CNT_W'(1);
      if (next_state == S_TRAP && state != S_TRAP) trap_cause <= next_cause;
    end
  end

endmodule

// File: tb/tb_mmips_ctrl_fsm.sv
// Scoreboard bench: per-cycle stimulus and expected control vectors are queued
// per instruction, then replayed cycle by cycle against the FSM outputs.
module tb_mmips_ctrl_fsm;

  localparam int T_RST = 0, T_FETCH = 1, T_DECODE = 2, T_MEMADR = 3, T_MEMRD = 4,
                 T_MEMWB = 5, T_MEMWR = 6, T_EXEC = 7, T_RWB = 8, T_ADDIWB = 9,
                 T_BRANCH = 10, T_JUMP = 11, T_TRAP = 12;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_c;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       trap;
    logic [1:0] trap_cause;
  } ctl_t;

  typedef struct {
    logic rdy;
    ctl_t exp;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, iord, ir_write, pc_write, pc_write_c;
  logic [1:0]  pc_src, alu_src_b, alu_op, trap_cause;
  logic        alu_src_a, reg_write, reg_dst, mem_to_reg, trap;
  logic [31:0] retired;

  int    errors = 0;
  int    checks = 0;
  int    exp_ret = 0;
  string cur_tag = "init";
  item_t sbq[$];

  always #5 clk = ~clk;

  mmips_ctrl_fsm #(.TIMEOUT_CYC(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_c(pc_write_c),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .trap(trap), .trap_cause(trap_cause),
    .retired(retired)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ctl_t ev(input int st, input logic rdy, input logic [1:0] cause);
    ctl_t c;
    c = '0;
    case (st)
      T_FETCH:  begin c.mem_req = 1; c.alu_src_b = 2'd1; c.ir_write = rdy; c.pc_write = rdy; end
      T_DECODE: c.alu_src_b = 2'd3;
      T_MEMADR: begin c.alu_src_a = 1; c.alu_src_b = 2'd2; end
      T_MEMRD:  begin c.mem_req = 1; c.iord = 1; end
      T_MEMWB:  begin c.reg_write = 1; c.mem_to_reg = 1; end
      T_MEMWR:  begin c.mem_req = 1; c.iord = 1; c.mem_we = 1; end
      T_EXEC:   begin c.alu_src_a = 1; c.alu_op = 2'd2; end
      T_RWB:    begin c.reg_write = 1; c.reg_dst = 1; end
      T_ADDIWB: c.reg_write = 1;
      T_BRANCH: begin c.alu_src_a = 1; c.alu_op = 2'd1; c.pc_write_c = 1; c.pc_src = 2'd1; end
      T_JUMP:   begin c.pc_write = 1; c.pc_src = 2'd2; end
      T_TRAP:   begin c.trap = 1; c.trap_cause = cause; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  function automatic ctl_t obs();
    ctl_t c;
    c = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_c, pc_src, alu_src_a,
         alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, trap, trap_cause};
    return c;
  endfunction

  task automatic push(input int st, input logic rdy, input logic [1:0] cause = 2'd0);
    item_t it;
    it.rdy = rdy;
    it.exp = ev(st, rdy, cause);
    sbq.push_back(it);
  endtask

  task automatic push_fetch(input int waits);
    for (int i = 0; i < waits; i++) push(T_FETCH, 1'b0);
    push(T_FETCH, 1'b1);
  endtask

  // Replays queued cycles; called at a falling edge, returns at a falling edge.
  task automatic drain();
    item_t it;
    while (sbq.size() > 0) begin
      it = sbq.pop_front();
      mem_ready = it.rdy;
      #1;
      check_eq(cur_tag, 32'(obs()), 32'(it.exp));
      @(negedge clk);
    end
  endtask

  task automatic run_instr(input string tag, input logic [5:0] op, input int fwait, input int mwait);
    cur_tag = tag;
    opcode = op;
    push_fetch(fwait);
    push(T_DECODE, 1'b1);
    case (op)
      6'h00: begin push(T_EXEC, 1'b1); push(T_RWB, 1'b1); end
      6'h23: begin
        push(T_MEMADR, 1'b1);
        for (int i = 0; i < mwait; i++) push(T_MEMRD, 1'b0);
        push(T_MEMRD, 1'b1);
        push(T_MEMWB, 1'b0);
      end
      6'h2B: begin
        push(T_MEMADR, 1'b0);
        for (int i = 0; i < mwait; i++) push(T_MEMWR, 1'b0);
        push(T_MEMWR, 1'b1);
      end
      6'h08: begin push(T_MEMADR, 1'b1); push(T_ADDIWB, 1'b1); end
      6'h04: push(T_BRANCH, 1'b1);
      default: push(T_JUMP, 1'b1);
    endcase
    drain();
    exp_ret++;
    check_eq({tag, "_retired"}, retired, 32'(exp_ret));
  endtask

  initial begin
    int req_seen;
    #2;
    check_eq("reset_outputs", 32'(obs()), 32'd0);
    check_eq("reset_retired", retired, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cur_tag = "rst_release";
    push(T_RST, 1'b0);
    drain();

    run_instr("add", 6'h00, 0, 0);
    run_instr("lw_slow", 6'h23, 0, 3);
    zero = 1'b1;
    run_instr("beq_taken", 6'h04, 0, 0);
    zero = 1'b0;
    run_instr("beq_not", 6'h04, 0, 0);
    run_instr("sw", 6'h2B, 1, 2);
    run_instr("addi_slowfetch", 6'h08, 3, 0);
    run_instr("j", 6'h02, 0, 0);
    run_instr("add_slowfetch", 6'h00, 3, 0);

    cur_tag = "lw_abort";
    opcode = 6'h23;
    push_fetch(0);
    push(T_DECODE, 1'b1);
    push(T_MEMADR, 1'b1);
    push(T_MEMRD, 1'b0);
    drain();
    mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_outputs", 32'(obs()), 32'd0);
    check_eq("async_rst_retired", retired, 32'd0);
    exp_ret = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cur_tag = "rst_after_abort";
    push(T_RST, 1'b0);
    drain();
    run_instr("add_after_rst", 6'h00, 0, 0);

    cur_tag = "illegal";
    opcode = 6'h3F;
    push_fetch(0);
    push(T_DECODE, 1'b1);
    push(T_TRAP, 1'b1, 2'd1);
    drain();
    req_seen = 0;
    for (int i = 0; i < 100; i++) begin
      mem_ready = 1'b1;
      #1;
      if (mem_req) req_seen++;
      @(negedge clk);
    end
    check_eq("trap_no_req", 32'(req_seen), 32'd0);
    check_eq("trap_sticky", 32'({trap, trap_cause}), 32'({1'b1, 2'd1}));
    check_eq("trap_retired", retired, 32'(exp_ret));

    rst_n = 1'b0;
    #1;
    check_eq("trap_cleared", 32'(obs()), 32'd0);
    exp_ret = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cur_tag = "timeout";
    opcode = 6'h00;
    push(T_RST, 1'b0);
    for (int i = 0; i < 4; i++) push(T_FETCH, 1'b0);
    push(T_TRAP, 1'b0, 2'd2);
    push(T_TRAP, 1'b1, 2'd2);
    drain();
    check_eq("timeout_retired", retired, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
